// File: rtl/vocab_matcher.sv
// Searches a null-separated vocabulary memory for one null-terminated input word.
// Optional ASCII case folding of both operands is enabled by defining VOCAB_MATCHER_CASE_FOLD_EN.
module vocab_matcher #(
    parameter int    DATA_WIDTH  = 8,
    parameter int    WORD_LENGTH = 8,
    parameter int    VOCAB_DEPTH = 64,
    parameter int    ADDR_WIDTH  = $clog2(VOCAB_DEPTH),
    parameter string INIT_FILE   = ""
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [WORD_LENGTH*DATA_WIDTH-1:0] word_i,
    input  logic                              wr_en_i,
    input  logic [ADDR_WIDTH-1:0]             wr_addr_i,
    input  logic [DATA_WIDTH-1:0]             wr_data_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              found_o,
    output logic [ADDR_WIDTH-1:0]             match_index_o,
    output logic [ADDR_WIDTH-1:0]             match_addr_o
);

    localparam int POS_W = $clog2(WORD_LENGTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VOCAB_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, COMPARE, SKIP, DONE} state_t;

    state_t                            state_q, state_d;
    logic [WORD_LENGTH*DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0]             addr_q, addr_d, index_q, index_d, wstart_q, wstart_d;
    logic [POS_W-1:0]                  pos_q, pos_d;
    logic                              busy_q, busy_d, done_q, done_d, found_q, found_d;
    logic [ADDR_WIDTH-1:0]             midx_q, midx_d, maddr_q, maddr_d;

    logic [DATA_WIDTH-1:0] mem [VOCAB_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] v_s, w_s;
    logic [ADDR_WIDTH-1:0] index_inc_s;
    logic rd_en_s, v_zero_s, eq_s, last_s;
    logic fin_s, hit_s, next_s, skip_s;

    // Positions past the last stored character read as the implicit terminator.
    function automatic logic [DATA_WIDTH-1:0] char_at(input logic [WORD_LENGTH*DATA_WIDTH-1:0] w,
                                                      input logic [POS_W-1:0] p);
        logic [DATA_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            c = (p == POS_W'(i)) ? w[i*DATA_WIDTH +: DATA_WIDTH] : c;
        end
        return c;
    endfunction

`ifdef VOCAB_MATCHER_CASE_FOLD_EN
    function automatic logic [DATA_WIDTH-1:0] fold(input logic [DATA_WIDTH-1:0] c);
        return ((DATA_WIDTH == 8) && (c >= DATA_WIDTH'(8'h41)) && (c <= DATA_WIDTH'(8'h5a)))
               ? c + DATA_WIDTH'(8'h20) : c;
    endfunction

    assign v_s = fold(rd_data_q);
    assign w_s = fold(char_at(word_q, pos_q));
`else
    assign v_s = rd_data_q;
    assign w_s = char_at(word_q, pos_q);
`endif

    assign v_zero_s    = (rd_data_q == '0);
    assign eq_s        = (v_s == w_s);
    assign last_s      = (addr_q == LAST_ADDR);
    assign index_inc_s = (index_q == LAST_ADDR) ? index_q : index_q + ADDR_WIDTH'(1);
    assign rd_en_s     = (state_q == FETCH) || (((state_q == COMPARE) || (state_q == SKIP)) && !fin_s);

    // Vocabulary memory: writes only while idle, synchronous read of the next address.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !busy_q) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_s) begin
            rd_data_q <= mem[addr_d];
        end
    end

    // Per-character decision; the last address ends the search unless it decides by itself.
    always_comb begin
        fin_s  = 1'b0;
        hit_s  = 1'b0;
        next_s = 1'b0;
        skip_s = 1'b0;
        if (state_q == COMPARE) begin
            if (eq_s && !v_zero_s) begin
                fin_s = last_s;
            end else if (eq_s) begin
                fin_s = 1'b1;
                hit_s = 1'b1;
            end else if (v_zero_s && (pos_q == '0)) begin
                fin_s = 1'b1;
            end else if (v_zero_s) begin
                fin_s  = last_s;
                next_s = !last_s;
            end else begin
                fin_s  = last_s;
                skip_s = !last_s;
            end
        end else if (state_q == SKIP) begin
            fin_s  = last_s;
            next_s = !last_s && v_zero_s;
            skip_s = !last_s && !v_zero_s;
        end else begin
            fin_s = 1'b0;
        end
    end

    // Next-state and result logic.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        addr_d   = addr_q;
        index_d  = index_q;
        wstart_d = wstart_q;
        pos_d    = pos_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        midx_d   = midx_q;
        maddr_d  = maddr_q;
        case (state_q)
            IDLE: begin
                if (start_i && !busy_q) begin
                    word_d   = word_i;
                    busy_d   = 1'b1;
                    found_d  = 1'b0;
                    midx_d   = '0;
                    maddr_d  = '0;
                    addr_d   = '0;
                    index_d  = '0;
                    wstart_d = '0;
                    pos_d    = '0;
                    state_d  = (word_i[DATA_WIDTH-1:0] == '0) ? DONE : FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: state_d = COMPARE;
            COMPARE, SKIP: begin
                if (fin_s) begin
                    state_d = DONE;
                    found_d = hit_s;
                    midx_d  = index_q;
                    maddr_d = hit_s ? wstart_q : '0;
                end else if (next_s) begin
                    state_d  = COMPARE;
                    index_d  = index_inc_s;
                    pos_d    = '0;
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    wstart_d = addr_q + ADDR_WIDTH'(1);
                end else if (skip_s) begin
                    state_d = SKIP;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    pos_d  = pos_q + POS_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            word_q   <= '0;
            addr_q   <= '0;
            index_q  <= '0;
            wstart_q <= '0;
            pos_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            midx_q   <= '0;
            maddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            addr_q   <= addr_d;
            index_q  <= index_d;
            wstart_q <= wstart_d;
            pos_q    <= pos_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            midx_q   <= midx_d;
            maddr_q  <= maddr_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign found_o       = found_q;
    assign match_index_o = midx_q;
    assign match_addr_o  = maddr_q;

endmodule

// File: tb/tb_vocab_matcher.sv
// Directed and randomized checks of vocab_matcher against a word-level reference model.
module tb_vocab_matcher;
    localparam int DW = 8;
    localparam int WL = 8;
    localparam int DEPTH = 64;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [WL*DW-1:0] word = '0;
    logic wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic busy, done, found;
    logic [AW-1:0] match_index, match_addr;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] mem_m [DEPTH];

    vocab_matcher #(.DATA_WIDTH(DW), .WORD_LENGTH(WL), .VOCAB_DEPTH(DEPTH), .ADDR_WIDTH(AW), .INIT_FILE("")) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .word_i(word),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .busy_o(busy), .done_o(done), .found_o(found),
        .match_index_o(match_index), .match_addr_o(match_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fold_m(input logic [7:0] c);
`ifdef VOCAB_MATCHER_CASE_FOLD_EN
        return (c >= 8'h41 && c <= 8'h5a) ? c + 8'h20 : c;
`else
        return c;
`endif
    endfunction

    function automatic logic [WL*DW-1:0] word_of(input string s);
        logic [WL*DW-1:0] w;
        w = '0;
        for (int i = 0; i < s.len() && i < WL; i++) w[i*8 +: 8] = s[i];
        return w;
    endfunction

    function automatic logic [7:0] alpha();
        logic [7:0] tbl [5];
        tbl = '{8'h61, 8'h62, 8'h63, 8'h41, 8'h42};
        return tbl[$urandom_range(0, 4)];
    endfunction

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // '|' in the string stands for a 0x00 byte
    task automatic load_str(input string s);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = (s[i] == 8'h7c) ? 8'h00 : s[i];
            wr(i, c);
            mem_m[i] = c;
        end
    endtask

    // Word-level reference: walk whole vocabulary words, not characters.
    task automatic model(input logic [WL*DW-1:0] w, output logic f, output int idx,
                         output int ad, output int cyc);
        int L, a, t, i;
        bit eq, dec;
        L = 0;
        while (L < WL && w[L*8 +: 8] != 8'h00) L++;
        f = 1'b0; idx = 0; ad = 0; cyc = 1;
        if (L == 0) return;
        a = 0; i = 0; dec = 0;
        while (!dec) begin
            if (mem_m[a] == 8'h00) begin
                idx = i; cyc = a + 3; dec = 1;
            end else begin
                t = a;
                while (t < DEPTH && mem_m[t] != 8'h00) t++;
                if (t == DEPTH) begin
                    idx = i; cyc = DEPTH + 2; dec = 1;
                end else begin
                    eq = (t - a == L);
                    for (int k = 0; k < L; k++)
                        if (eq && fold_m(mem_m[a+k]) != fold_m(w[k*8 +: 8])) eq = 0;
                    if (eq) begin
                        f = 1'b1; idx = i; ad = a; cyc = t + 3; dec = 1;
                    end else if (t == DEPTH - 1) begin
                        idx = i; cyc = DEPTH + 2; dec = 1;
                    end else begin
                        i = (i < DEPTH - 1) ? i + 1 : i;
                        a = t + 1;
                    end
                end
            end
        end
    endtask

    task automatic search(input string tag, input logic [WL*DW-1:0] w, input bit poke);
        logic ef;
        int eidx, eaddr, ecyc, n;
        model(w, ef, eidx, eaddr, ecyc);
        @(negedge clk);
        word = w; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; word = ~w;
        chk({tag, "_busy_accept"}, busy, 1);
        n = 0;
        while (!done && n < 200) begin
            if (poke) chk({tag, "_busy_hold"}, busy, 1);
            start = (poke && n == 3) ? 1'b1 : 1'b0;
            if (start) word = word_of("cat");
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_cycles"}, n, ecyc);
        chk({tag, "_found"}, found, ef);
        chk({tag, "_index"}, match_index, eidx);
        chk({tag, "_addr"}, match_addr, eaddr);
        chk({tag, "_busy_done"}, busy, 0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_found_held"}, found, ef);
    endtask

    initial begin
        logic [WL*DW-1:0] w;
        logic ef;
        int eidx, eaddr, ecyc, n, p, len, s, k;
        int starts[$];
        bit mode_end, seen;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_found", found, 0);
        chk("reset_index", match_index, 0);
        chk("reset_addr", match_addr, 0);
        @(negedge clk); rst = 1'b0;

        load_str("cat|dog||");
        search("dog", word_of("dog"), 0);
        search("do", word_of("do"), 0);
        search("cow", word_of("cow"), 1);
        search("empty", word_of(""), 0);
        search("DOG", word_of("DOG"), 0);
        load_str("abcdefgh||");
        search("full", word_of("abcdefgh"), 0);
        search("prefix", word_of("abcdefg"), 0);

        load_str("cat|dog||");
        @(negedge clk); word = word_of("dog"); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1; #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_found", found, 0);
        chk("midrst_index", match_index, 0);
        @(posedge clk); @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (15) begin @(posedge clk); #1; if (done) seen = 1; end
        chk("midrst_no_done", seen, 0);

        model(word_of("dog"), ef, eidx, eaddr, ecyc);
        @(negedge clk); word = word_of("dog"); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wr(4, 8'h78);
        n = 0;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        chk("busywr_done_seen", done, 1);
        chk("busywr_found", found, ef);
        chk("busywr_index", match_index, eidx);
        search("after_busywr", word_of("dog"), 0);

        for (int it = 0; it < 40; it++) begin
            mode_end = ($urandom_range(0, 3) != 0);
            p = 0;
            starts.delete();
            while (p < DEPTH) begin
                if (mode_end && p > 0 && $urandom_range(0, 4) == 0) begin
                    mem_m[p] = 8'h00; p++;
                    while (p < DEPTH) begin mem_m[p] = 8'($urandom_range(0, 255)); p++; end
                end else begin
                    len = $urandom_range(1, 6);
                    starts.push_back(p);
                    for (int j = 0; j < len && p < DEPTH; j++) begin mem_m[p] = alpha(); p++; end
                    if (p < DEPTH) begin mem_m[p] = 8'h00; p++; end
                end
            end
            for (int a = 0; a < DEPTH; a++) wr(a, mem_m[a]);
            w = '0;
            if ($urandom_range(0, 1) == 1 && starts.size() > 0) begin
                s = starts[$urandom_range(0, starts.size() - 1)];
                k = 0;
                while (k < WL && s + k < DEPTH && mem_m[s+k] != 8'h00) begin
                    w[k*8 +: 8] = mem_m[s+k]; k++;
                end
            end else begin
                len = $urandom_range(0, WL);
                for (int j = 0; j < len; j++) w[j*8 +: 8] = alpha();
            end
            search($sformatf("rnd%0d", it), w, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
